seq_magnitude_comparator: RTL and testbench

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/seq_magnitude_comparator_pkg.sv | 16 +
 rtl/seq_magnitude_comparator_if.sv | 34 +++
 rtl/seq_magnitude_comparator_bcs_stage.sv | 15 +
 rtl/seq_magnitude_comparator.sv | 137 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
//   state_e      : controller states (idle, scanning chunks, result held)
//   steps_width  : width needed to count 0..nch examined chunks
package comparator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned steps_width(input int unsigned nch);
    return $clog2(nch + 1);
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for seq_magnitude_comparator.
//   in_valid/in_ready   : request handshake carrying a, b, signed_mode
//   out_valid/out_ready : result handshake carrying eq, gt, lt, steps
// master drives requests and consumes results; slave is the comparator.
interface seq_magnitude_comparator_if
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
);
  localparam int unsigned StepsW = steps_width(WIDTH / BPC);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              signed_mode;
  logic              out_valid;
  logic              out_ready;
  logic              eq;
  logic              gt;
  logic              lt;
  logic [StepsW-1:0] steps;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, eq, gt, lt, steps
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, eq, gt, lt, steps
  );
endinterface

// File: rtl/seq_magnitude_comparator_bcs_stage.sv
// One bit of the MSB-first compare recurrence.
//   a_i, b_i     : operand bits at this position
//   e_in, g_in   : "equal so far" / "greater so far" from more significant bits
//   e_out, g_out : updated flags after this bit
module bcs_stage (
  input  logic a_i,
  input  logic b_i,
  input  logic e_in,
  input  logic g_in,
  output logic e_out,
  output logic g_out
);
  assign g_out = g_in | (e_in & a_i & ~b_i);
  assign e_out = e_in & ~(a_i ^ b_i);
endmodule

// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: scans BPC bits per cycle from MSB to LSB,
// stopping early at the first differing chunk.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seq_magnitude_comparator_if (request + result)
module seq_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input logic                       clk,
  input logic                       rst_n,
  seq_magnitude_comparator_if.slave bus
);
  localparam int unsigned NCH    = (BPC >= 1) ? WIDTH / BPC : 1;
  localparam int unsigned StepsW = steps_width(NCH);
  localparam int unsigned IdxW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] MsbMask = {1'b1, {(WIDTH-1){1'b0}}};

  if (BPC < 1) begin : g_bad_bpc
    $error("seq_magnitude_comparator: BPC must be >= 1");
  end else if ((WIDTH % BPC) != 0) begin : g_bad_width
    $error("seq_magnitude_comparator: WIDTH must be a multiple of BPC");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              e_q, e_d, g_q, g_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [StepsW-1:0] steps_q, steps_d;
  logic              eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  // Current chunk lands in the low BPC bits after the shift.
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [BPC:0]     e_ch, g_ch;
  logic             e_nxt, g_nxt;

  assign a_sh    = a_q >> (idx_q * BPC);
  assign b_sh    = b_q >> (idx_q * BPC);
  assign e_ch[0] = e_q;
  assign g_ch[0] = g_q;

  for (genvar i = 0; i < BPC; i++) begin : g_stage
    bcs_stage u_stage (
      .a_i   (a_sh[BPC-1-i]),
      .b_i   (b_sh[BPC-1-i]),
      .e_in  (e_ch[i]),
      .g_in  (g_ch[i]),
      .e_out (e_ch[i+1]),
      .g_out (g_ch[i+1])
    );
  end

  assign e_nxt = e_ch[BPC];
  assign g_nxt = g_ch[BPC];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    e_d     = e_q;
    g_d     = g_q;
    idx_d   = idx_q;
    steps_d = steps_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          // Flipping the sign bit maps two's complement onto offset binary,
          // so the unsigned recurrence gives the signed ordering.
          a_d     = bus.a ^ ({WIDTH{bus.signed_mode}} & MsbMask);
          b_d     = bus.b ^ ({WIDTH{bus.signed_mode}} & MsbMask);
          e_d     = 1'b1;
          g_d     = 1'b0;
          idx_d   = IdxW'(NCH - 1);
          steps_d = '0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        e_d     = e_nxt;
        g_d     = g_nxt;
        steps_d = steps_q + StepsW'(1);
        idx_d   = idx_q - IdxW'(1);
        if (!e_nxt || (idx_q == '0)) begin
          eq_d    = e_nxt;
          gt_d    = g_nxt;
          lt_d    = ~e_nxt & ~g_nxt;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      idx_q   <= '0;
      steps_q <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      e_q     <= e_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
      steps_q <= steps_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.steps     = steps_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(8), .BPC(1)) if1 ();
  seq_magnitude_comparator_if #(.WIDTH(8), .BPC(4)) if4 ();

  seq_magnitude_comparator #(.WIDTH(8), .BPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  seq_magnitude_comparator #(.WIDTH(8), .BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  // Shared stimulus; sel picks which instance sees the handshakes.
  int         sel = 0;
  logic       vld = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       sm = 1'b0;

  assign if1.in_valid    = vld && (sel == 0);
  assign if4.in_valid    = vld && (sel == 1);
  assign if1.out_ready   = rdy && (sel == 0);
  assign if4.out_ready   = rdy && (sel == 1);
  assign if1.a           = a_in;
  assign if4.a           = a_in;
  assign if1.b           = b_in;
  assign if4.b           = b_in;
  assign if1.signed_mode = sm;
  assign if4.signed_mode = sm;

  logic       o_ready, o_valid, o_eq, o_gt, o_lt;
  logic [3:0] o_steps;
  assign o_ready = (sel == 1) ? if4.in_ready  : if1.in_ready;
  assign o_valid = (sel == 1) ? if4.out_valid : if1.out_valid;
  assign o_eq    = (sel == 1) ? if4.eq        : if1.eq;
  assign o_gt    = (sel == 1) ? if4.gt        : if1.gt;
  assign o_lt    = (sel == 1) ? if4.lt        : if1.lt;
  assign o_steps = (sel == 1) ? 4'(if4.steps) : if1.steps;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: compare as integers; steps = position of first differing chunk.
  task automatic model(input int bpc, input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic e, output logic g, output logic l, output int st);
    int sa, sb, nch, mask;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    e = (sa == sb);
    g = (sa > sb);
    l = (sa < sb);
    nch = 8 / bpc;
    mask = (1 << bpc) - 1;
    st = nch;
    for (int c = nch - 1; c >= 0; c--) begin
      if (((int'(a) >> (c * bpc)) & mask) != ((int'(b) >> (c * bpc)) & mask)) begin
        st = nch - c;
        break;
      end
    end
  endtask

  // Issue one request, wait for the result, report latency; leaves DUT in DONE.
  task automatic issue(input int s, input logic [7:0] a, input logic [7:0] b, input logic m,
                       output int lat, output logic ok);
    int guard;
    @(negedge clk);
    sel = s; a_in = a; b_in = b; sm = m; vld = 1'b1;
    guard = 0;
    while (!o_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    ok = o_ready;
    if (!ok) begin
      check("in_ready_timeout", 0, 1);
      vld = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    vld = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    ok = o_valid;
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask

  task automatic release_result();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check("out_valid_low_after_pop", int'(o_valid), 0);
    check("in_ready_after_pop", int'(o_ready), 1);
  endtask

  task automatic run_one(input string tag, input int s, input logic [7:0] a, input logic [7:0] b,
                         input logic m, input logic xe, input logic xg, input logic xl,
                         input int xs);
    int lat;
    logic ok;
    issue(s, a, b, m, lat, ok);
    if (!ok) return;
    check({tag, "_eq"}, int'(o_eq), int'(xe));
    check({tag, "_gt"}, int'(o_gt), int'(xg));
    check({tag, "_lt"}, int'(o_lt), int'(xl));
    check({tag, "_steps"}, int'(o_steps), xs);
    check({tag, "_latency"}, lat, xs);
    release_result();
  endtask

  typedef struct {
    int         s;
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic       xe;
    logic       xg;
    logic       xl;
    int         xs;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int lat;
    logic ok, hold_eq, hold_gt, hold_lt;
    logic me, mg, ml;
    int ms;
    logic [3:0] hold_steps;

    vecs.push_back('{0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8});
    vecs.push_back('{0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{0, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{0, 8'h12, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 8});
    vecs.push_back('{0, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 8});
    vecs.push_back('{0, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{1, 8'hA3, 8'hA7, 1'b0, 1'b0, 1'b0, 1'b1, 2});
    vecs.push_back('{1, 8'h3C, 8'h2C, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{1, 8'h55, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{1, 8'h8F, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1});

    // Reset state for both instances.
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("reset_in_ready", int'(o_ready), 1);
      check("reset_out_valid", int'(o_valid), 0);
      check("reset_flags", int'({o_eq, o_gt, o_lt}), 0);
      check("reset_steps", int'(o_steps), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_one($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].m,
              vecs[i].xe, vecs[i].xg, vecs[i].xl, vecs[i].xs);

    // Result held under back-pressure; requests during DONE are ignored.
    issue(0, 8'h5A, 8'h5B, 1'b0, lat, ok);
    if (ok) begin
      hold_eq = o_eq; hold_gt = o_gt; hold_lt = o_lt; hold_steps = o_steps;
      check("hold_lt_initial", int'(o_lt), 1);
      check("hold_steps_initial", int'(o_steps), 8);
      vld = 1'b1; a_in = 8'h00; b_in = 8'hFF; sm = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("hold_out_valid", int'(o_valid), 1);
        check("hold_in_ready", int'(o_ready), 0);
        check("hold_flags", int'({o_eq, o_gt, o_lt}), int'({hold_eq, hold_gt, hold_lt}));
        check("hold_steps", int'(o_steps), int'(hold_steps));
      end
      vld = 1'b0;
      release_result();
    end

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    sel = 0; a_in = 8'h01; b_in = 8'h00; sm = 1'b0; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_in_run", int'(o_ready), 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", int'(o_valid), 0);
    check("async_rst_in_ready", int'(o_ready), 1);
    check("async_rst_steps", int'(o_steps), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("post_reset", 0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8);

    // Randomized against the reference model.
    for (int n = 0; n < 300; n++) begin
      int s;
      logic [7:0] ra, rb;
      logic rm;
      s = int'($urandom_range(1, 0));
      ra = 8'($urandom);
      rb = ($urandom_range(3, 0) == 0) ? ra : 8'($urandom);
      rm = 1'($urandom);
      model((s == 1) ? 4 : 1, ra, rb, rm, me, mg, ml, ms);
      run_one("rand", s, ra, rb, rm, me, mg, ml, ms);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
